// File: rtl/time_uart_tx_pkg.sv
// Shared constants, types and helpers for the time-of-day UART reporter.
package time_uart_tx_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam int unsigned MSG_LEN = 10;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned BIT_W   = 3;

  // Snapshot of the six clock digits, most significant digit first.
  typedef struct packed {
    logic [1:0] h_tens;
    logic [3:0] h_units;
    logic [2:0] m_tens;
    logic [3:0] m_units;
    logic [2:0] s_tens;
    logic [3:0] s_units;
  } time_digits_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_NEXT
  } tx_state_t;

  // Clock cycles per serial bit.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

  // Character idx of the "HH:MM:SS\r\n" report; digits are not range-checked.
  function automatic logic [7:0] msg_byte(input time_digits_t d,
                                          input logic [IDX_W-1:0] idx);
    case (idx)
      4'd0:    msg_byte = ASCII_ZERO + 8'(d.h_tens);
      4'd1:    msg_byte = ASCII_ZERO + 8'(d.h_units);
      4'd2:    msg_byte = ASCII_COLON;
      4'd3:    msg_byte = ASCII_ZERO + 8'(d.m_tens);
      4'd4:    msg_byte = ASCII_ZERO + 8'(d.m_units);
      4'd5:    msg_byte = ASCII_COLON;
      4'd6:    msg_byte = ASCII_ZERO + 8'(d.s_tens);
      4'd7:    msg_byte = ASCII_ZERO + 8'(d.s_units);
      4'd8:    msg_byte = ASCII_CR;
      default: msg_byte = ASCII_LF;
    endcase
  endfunction

endpackage

// File: rtl/time_uart_tx_byte.sv
// 8N1 byte serialiser with a valid/ready handshake; the line is driven from a flop.
module uart_tx_byte #(
  parameter int unsigned DIV = 1085
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx,
  output logic       bit_done_c
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic [8:0]       shreg;
  logic [3:0]       bits_left;

  // Marks the final cycle of every bit period while a frame is on the line.
  assign bit_done_c = ~ready & (cnt == '0);

  // Frame sequencing: start bit on accept, then data LSB first, then stop bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready     <= 1'b1;
      tx        <= 1'b1;
      cnt       <= '0;
      shreg     <= '1;
      bits_left <= '0;
    end else if (ready) begin
      if (valid) begin
        ready     <= 1'b0;
        tx        <= 1'b0;
        shreg     <= {1'b1, data};
        cnt       <= CNT_W'(DIV - 1);
        bits_left <= 4'd9;
      end
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end else if (bits_left == 4'd0) begin
      // stop bit complete; line is already high
      ready <= 1'b1;
    end else begin
      tx        <= shreg[0];
      shreg     <= {1'b1, shreg[8:1]};
      bits_left <= bits_left - 1'b1;
      cnt       <= CNT_W'(DIV - 1);
    end
  end

endmodule

// File: rtl/time_uart_tx.sv
// Sends "HH:MM:SS\r\n" over UART for every accepted 1 Hz tick.
module time_uart_tx
  import time_uart_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 125000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic [1:0] COUNT_2h,
  input  logic [3:0] COUNT_10h,
  input  logic [2:0] COUNT_6m,
  input  logic [3:0] COUNT_10m,
  input  logic [2:0] COUNT_6,
  input  logic [3:0] COUNT_10,
  output logic       TX,
  output logic       BUSY,
  output logic       OVERRUN
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

  tx_state_t        state;
  time_digits_t     live;
  time_digits_t     snap;
  time_digits_t     sel_digits;
  logic [IDX_W-1:0] char_idx;
  logic [IDX_W-1:0] sel_idx;
  logic [BIT_W-1:0] bit_cnt;
  logic             byte_valid_c;
  logic [7:0]       byte_data_c;
  logic             byte_ready;
  logic             bit_done_c;

  assign live = {COUNT_2h, COUNT_10h, COUNT_6m, COUNT_10m, COUNT_6, COUNT_10};

  // First character comes straight from the live digits so the start bit is not delayed.
  always_comb begin
    byte_valid_c = 1'b0;
    sel_digits   = snap;
    sel_idx      = '0;
    if (state == ST_IDLE) begin
      byte_valid_c = ENABLE & byte_ready;
      sel_digits   = live;
    end else if (state == ST_NEXT) begin
      byte_valid_c = (char_idx != LAST_IDX) & byte_ready;
      sel_idx      = char_idx + 1'b1;
    end
    byte_data_c = msg_byte(sel_digits, sel_idx);
  end

  // Report sequencer: tracks frame phases and steps through the ten characters.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= ST_IDLE;
      BUSY     <= 1'b0;
      OVERRUN  <= 1'b0;
      char_idx <= '0;
      bit_cnt  <= '0;
      snap     <= '0;
    end else begin
      OVERRUN <= ENABLE & (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (byte_valid_c) begin
            snap     <= live;
            char_idx <= '0;
            bit_cnt  <= '0;
            BUSY     <= 1'b1;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (bit_done_c) begin
            bit_cnt <= '0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_done_c) begin
            if (bit_cnt == BIT_W'(7)) begin
              bit_cnt <= '0;
              state   <= ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (bit_done_c) state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (char_idx == LAST_IDX) begin
            char_idx <= '0;
            BUSY     <= 1'b0;
            state    <= ST_IDLE;
          end else if (byte_valid_c) begin
            char_idx <= char_idx + 1'b1;
            state    <= ST_START;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .DIV (DIV)
  ) u_byte (
    .clk        (CLK),
    .rst        (RESET),
    .valid      (byte_valid_c),
    .data       (byte_data_c),
    .ready      (byte_ready),
    .tx         (TX),
    .bit_done_c (bit_done_c)
  );

endmodule

// File: tb/tb_time_uart_tx.sv
// Scoreboard bench: stimulus queues expected bytes, UART monitors decode TX and compare.
module tb_time_uart_tx;

  localparam int SDIV = 16;
  localparam int BDIV = 1085;

  logic clk = 1'b0;
  logic rst, en, tx, busy, ovr;
  logic [1:0] h2;  logic [3:0] h10; logic [2:0] m6; logic [3:0] m10; logic [2:0] s6; logic [3:0] s10;
  logic rst_big, en_big, tx_big, busy_big, ovr_big;
  logic [1:0] bh2; logic [3:0] bh10; logic [2:0] bm6; logic [3:0] bm10; logic [2:0] bs6; logic [3:0] bs10;

  int errors = 0;
  int checks = 0;
  int rst_cnt = 0;
  int rst_big_cnt = 0;
  logic mon_en = 1'b0;
  logic big_done = 1'b0;
  logic [7:0] q_small[$];
  logic [7:0] q_big[$];

  always #5 clk = ~clk;

  time_uart_tx #(.CLK_FREQ(16), .BAUD(1)) u_dut (
    .CLK(clk), .RESET(rst), .ENABLE(en),
    .COUNT_2h(h2), .COUNT_10h(h10), .COUNT_6m(m6), .COUNT_10m(m10), .COUNT_6(s6), .COUNT_10(s10),
    .TX(tx), .BUSY(busy), .OVERRUN(ovr)
  );

  time_uart_tx #(.CLK_FREQ(125000000), .BAUD(115200)) u_big (
    .CLK(clk), .RESET(rst_big), .ENABLE(en_big),
    .COUNT_2h(bh2), .COUNT_10h(bh10), .COUNT_6m(bm6), .COUNT_10m(bm10), .COUNT_6(bs6), .COUNT_10(bs10),
    .TX(tx_big), .BUSY(busy_big), .OVERRUN(ovr_big)
  );

  always @(posedge clk) begin
    if (rst) rst_cnt <= rst_cnt + 1;
    if (rst_big) rst_big_cnt <= rst_big_cnt + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic line_tx(input int which);
    return (which == 0) ? tx : tx_big;
  endfunction

  function automatic int rst_seen(input int which);
    return (which == 0) ? rst_cnt : rst_big_cnt;
  endfunction

  task automatic check_byte(input int which, input logic [7:0] b, input logic stop);
    logic [7:0] exp_b;
    chk("rx_stop_bit", int'(stop), 1);
    if ((which == 0 && q_small.size() == 0) || (which == 1 && q_big.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL rx_unexpected_byte: dut %0d got 0x%0h, expected no byte", which, b);
    end else begin
      exp_b = (which == 0) ? q_small.pop_front() : q_big.pop_front();
      chk((which == 0) ? "rx_byte" : "rx_byte_default", int'(b), int'(exp_b));
    end
  endtask

  // Mid-bit sampling decoder; frames overlapping a reset are discarded.
  task automatic rx_monitor(input int which, input int div);
    logic [7:0] b;
    int r0;
    forever begin
      @(negedge clk);
      if (line_tx(which) == 1'b0) begin
        r0 = rst_seen(which);
        b = '0;
        for (int c = 1; c <= 9*div + div/2; c++) begin
          @(negedge clk);
          if ((c % div) == div/2 && c >= div && c < 9*div) b[c/div - 1] = line_tx(which);
        end
        if (rst_seen(which) == r0) check_byte(which, b, line_tx(which));
      end
    end
  endtask

  initial begin wait (mon_en); rx_monitor(0, SDIV); end
  initial begin wait (mon_en); rx_monitor(1, BDIV); end

  // One report on the small DUT with optional digit change, overrun tick, reset or waveform check.
  task automatic run_report(input logic [1:0] a, input logic [3:0] b, input logic [2:0] c,
                            input logic [3:0] d, input logic [2:0] e, input logic [3:0] f,
                            input int n_exp, input int chg_at, input int ovr_at, input int rst_at,
                            input logic wave, input int exp_busy);
    logic [7:0] bytes[10];
    logic [9:0] frame;
    int i;
    int busy_cycles;
    bytes[0] = 8'h30 + 8'(a); bytes[1] = 8'h30 + 8'(b); bytes[2] = 8'h3A;
    bytes[3] = 8'h30 + 8'(c); bytes[4] = 8'h30 + 8'(d); bytes[5] = 8'h3A;
    bytes[6] = 8'h30 + 8'(e); bytes[7] = 8'h30 + 8'(f); bytes[8] = 8'h0D; bytes[9] = 8'h0A;
    frame = {1'b1, bytes[0], 1'b0};
    for (int k = 0; k < n_exp; k++) q_small.push_back(bytes[k]);
    h2 = a; h10 = b; m6 = c; m10 = d; s6 = e; s10 = f;
    @(negedge clk);
    chk("tx_idle_before_enable", int'(tx), 1);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    chk("start_edge_after_enable", int'(tx), 0);
    chk("busy_after_enable", int'(busy), 1);
    i = 1;
    busy_cycles = 0;
    while ((busy || (ovr_at > 0 && i <= ovr_at + 2)) && i < 3000) begin
      if (busy) busy_cycles++;
      if (wave && i <= 10*SDIV) chk("wave_bit", int'(tx), int'(frame[(i-1)/SDIV]));
      if (wave && i == 10*SDIV + 1) chk("wave_next_high", int'(tx), 1);
      if (i == chg_at) begin
        h2 = 2'd1; h10 = 4'd8; m6 = 3'd4; m10 = 4'd0; s6 = 3'd2; s10 = 4'd7;
      end
      if (ovr_at > 0 && i == ovr_at) begin
        chk("overrun_low_before", int'(ovr), 0);
        en = 1'b1;
      end
      if (ovr_at > 0 && i == ovr_at + 1) begin
        en = 1'b0;
        chk("overrun_pulse", int'(ovr), 1);
      end
      if (ovr_at > 0 && i == ovr_at + 2) begin
        chk("overrun_one_cycle", int'(ovr), 0);
        if (ovr_at >= 10*(10*SDIV + 1)) chk("end_tick_not_accepted", int'(busy), 0);
      end
      if (rst_at > 0 && i == rst_at) rst = 1'b1;
      @(negedge clk);
      i++;
    end
    if (rst_at > 0) begin
      chk("reset_abort_cycle", i, rst_at + 1);
      chk("reset_abort_tx", int'(tx), 1);
      chk("reset_abort_busy", int'(busy), 0);
      rst = 1'b0;
    end
    chk("busy_cycles", busy_cycles, exp_busy);
    repeat (200) @(negedge clk);
  endtask

  initial begin : watchdog
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish within 60000 cycles");
    $fatal(1);
  end

  // Default-parameter DUT: bit timing and the first two report characters.
  initial begin : big_seq
    int run;
    wait (mon_en);
    bh2 = 2'd1; bh10 = 4'd2; bm6 = 3'd3; bm10 = 4'd4; bs6 = 3'd5; bs10 = 4'd6;
    q_big.push_back(8'h31);
    q_big.push_back(8'h32);
    @(negedge clk);
    en_big = 1'b1;
    @(negedge clk);
    en_big = 1'b0;
    chk("default_start_edge", int'(tx_big), 0);
    run = 0;
    while (tx_big == 1'b0 && run < 3000) begin run++; @(negedge clk); end
    chk("default_start_bit_len", run, BDIV);
    run = 0;
    while (tx_big == 1'b1 && run < 3000) begin run++; @(negedge clk); end
    chk("default_data0_len", run, BDIV);
    run = 0;
    while (q_big.size() != 0 && run < 30000) begin run++; @(negedge clk); end
    chk("default_bytes_received", q_big.size(), 0);
    chk("default_busy_mid_report", int'(busy_big), 1);
    big_done = 1'b1;
  end

  initial begin : main_seq
    int run;
    rst = 1'b1; en = 1'b0; rst_big = 1'b1; en_big = 1'b0;
    h2 = '0; h10 = '0; m6 = '0; m10 = '0; s6 = '0; s10 = '0;
    bh2 = '0; bh10 = '0; bm6 = '0; bm10 = '0; bs6 = '0; bs10 = '0;
    repeat (3) @(negedge clk);
    chk("reset_tx", int'(tx), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_overrun", int'(ovr), 0);
    rst = 1'b0; rst_big = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    // reset and enable together: reset wins
    rst = 1'b1; en = 1'b1;
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    chk("reset_priority_busy", int'(busy), 0);
    chk("reset_priority_tx", int'(tx), 1);
    @(negedge clk);
    chk("reset_priority_idle", int'(busy), 0);
    chk("reset_priority_overrun", int'(ovr), 0);

    run_report(2'd2, 4'd3, 3'd5, 4'd9, 3'd5, 4'd9, 10, 0, 0, 0, 1'b0, 1610);
    run_report(2'd0, 4'd0, 3'd0, 4'd0, 3'd0, 4'd0, 10, 0, 0, 0, 1'b1, 1610);
    run_report(2'd1, 4'd2, 3'd3, 4'd4, 3'd5, 4'd6, 10, 300, 500, 0, 1'b0, 1610);
    run_report(2'd2, 4'd0, 3'd1, 4'd5, 3'd3, 4'd7, 10, 0, 1610, 0, 1'b0, 1610);
    run_report(2'd1, 4'd1, 3'd4, 4'd8, 3'd2, 4'd2, 4, 0, 0, 700, 1'b0, 700);
    run_report(2'd1, 4'd9, 3'd0, 4'd7, 3'd4, 4'd5, 10, 0, 0, 0, 1'b0, 1610);

    chk("all_bytes_received", q_small.size(), 0);
    run = 0;
    while (!big_done && run < 40000) begin run++; @(negedge clk); end
    chk("default_sequence_done", int'(big_done), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
